// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared flag indices, reset image and status type for the P register
//
// Purpose: constants and types shared by cpu_status_reg and its flag cells.
// Contents:
//   FLAG_*   bit positions of each flag in the P byte
//   RESET_P  P image after reset (I=1, unused bit5=1)
//   status_t the six stored flags
//   pack_p   builds a P byte from stored flags plus the B bit value
package cpu_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] RESET_P = 8'h24;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } status_t;

  // Bit5 always reads 1; bit4 is not stored and comes from the caller.
  function automatic logic [7:0] pack_p(input status_t s, input logic b);
    return {s.n, s.v, 1'b1, b, s.d, s.i, s.z, s.c};
  endfunction

endpackage

// File: rtl/cpu_status_reg_if.sv
// rtl/cpu_status_reg_if.sv - ALU/decoder to status register bundle
//
// Purpose: groups the ALU result, decoder flag controls and status outputs.
// Modports:
//   master  ALU/decoder side: drives alu_*, upd_*, bit_op, data_in, load_p,
//           explicit flag ops, irq_entry, push_brk; reads the status outputs
//   slave   status register side: the reverse
// Optional: SET_OVERFLOW_PIN_EN adds the so_n input (set-overflow pin).
interface cpu_status_reg_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             alu_overflow;
  logic             alu_valid;
  logic             upd_nz;
  logic             upd_c;
  logic             upd_v;
  logic             bit_op;
  logic [WIDTH-1:0] data_in;
  logic             load_p;
  logic             set_c;
  logic             clr_c;
  logic             set_i;
  logic             clr_i;
  logic             set_d;
  logic             clr_d;
  logic             clr_v;
  logic             irq_entry;
  logic             push_brk;
`ifdef SET_OVERFLOW_PIN_EN
  logic             so_n;
`endif
  logic [WIDTH-1:0] p_out;
  logic             carry_q;
  logic [WIDTH-1:0] push_image;
  logic [WIDTH-1:0] result_q;

  modport master (
    output alu_out, alu_carry, alu_overflow, alu_valid,
    output upd_nz, upd_c, upd_v, bit_op, data_in, load_p,
    output set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
    output irq_entry, push_brk,
`ifdef SET_OVERFLOW_PIN_EN
    output so_n,
`endif
    input  p_out, carry_q, push_image, result_q
  );

  modport slave (
    input  alu_out, alu_carry, alu_overflow, alu_valid,
    input  upd_nz, upd_c, upd_v, bit_op, data_in, load_p,
    input  set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
    input  irq_entry, push_brk,
`ifdef SET_OVERFLOW_PIN_EN
    input  so_n,
`endif
    output p_out, carry_q, push_image, result_q
  );

endinterface

// File: rtl/cpu_status_reg_flag_bit_cell.sv
// rtl/cpu_status_reg_flag_bit_cell.sv - one status flag flop with priority next-state mux
//
// Purpose: single P flag. Priority, highest first:
//   rst > load_en > set > clr > alt_en > upd_en > hold
// Ports:
//   clk, rst           clock, synchronous active-high reset (to RST_VAL)
//   load_en/load_val   PLP/RTI load
//   set, clr           explicit flag ops (set wins over clr)
//   alt_en/alt_val     secondary source (BIT operand, set-overflow pin)
//   upd_en/upd_val     ALU result update
//   q                  flag value
module flag_bit_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  input  logic load_val,
  input  logic set,
  input  logic clr,
  input  logic alt_en,
  input  logic alt_val,
  input  logic upd_en,
  input  logic upd_val,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load_en) begin
      q <= load_val;
    end else if (set) begin
      q <= 1'b1;
    end else if (clr) begin
      q <= 1'b0;
    end else if (alt_en) begin
      q <= alt_val;
    end else if (upd_en) begin
      q <= upd_val;
    end
  end

endmodule

// File: rtl/cpu_status_reg.sv
// rtl/cpu_status_reg.sv - 6502 processor status register stage after the ALU
//
// Purpose: holds the ALU result, commits N/V/Z/C from the ALU under decoder
// control, executes flag instructions, BIT, PLP/RTI loads and interrupt entry.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   bus      cpu_status_reg_if.slave: ALU result/strobe, decoder controls,
//            data_in, push_brk in; p_out, carry_q, push_image, result_q out
// Parameters: WIDTH (8), RESET_P (P image after reset)
// Optional: SET_OVERFLOW_PIN_EN adds so_n; a registered falling edge sets V.
module cpu_status_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RESET_P = cpu_pkg::RESET_P
) (
  input logic              clk,
  input logic              rst,
  cpu_status_reg_if.slave  bus
);

  status_t          st;
  logic [WIDTH-1:0] result_r;

  // ALU-derived updates only count while the ALU result strobe is high.
  logic nz_en;
  logic c_en;
  logic v_en;
  logic bit_en;
  logic res_zero;

  assign nz_en    = bus.alu_valid & bus.upd_nz;
  assign c_en     = bus.alu_valid & bus.upd_c;
  assign v_en     = bus.alu_valid & bus.upd_v;
  assign bit_en   = bus.alu_valid & bus.bit_op;
  assign res_zero = (bus.alu_out == '0);

  // B and the constant bit are not stored; their data_in bits are dropped.
  logic unused_data_bits;
  assign unused_data_bits = ^bus.data_in[FLAG_U:FLAG_B];

  logic v_alt_en;
  logic v_alt_val;

`ifdef SET_OVERFLOW_PIN_EN
  // so_q samples the pin, so_prev is its previous value; the edge pulse is
  // one cycle wide, so a pin held low cannot re-set V after clr_v.
  logic so_q;
  logic so_prev;
  logic so_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      so_q    <= 1'b1;
      so_prev <= 1'b1;
    end else begin
      so_q    <= bus.so_n;
      so_prev <= so_q;
    end
  end

  assign so_fall   = so_prev & ~so_q;
  // Pin edge ranks below clr_v (clr input) and above BIT/upd_v.
  assign v_alt_en  = so_fall | bit_en;
  assign v_alt_val = so_fall | bus.data_in[FLAG_V];
`else
  assign v_alt_en  = bit_en;
  assign v_alt_val = bus.data_in[FLAG_V];
`endif

  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_N])) u_flag_n (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_N]),
    .set(1'b0), .clr(1'b0),
    .alt_en(bit_en), .alt_val(bus.data_in[FLAG_N]),
    .upd_en(nz_en), .upd_val(bus.alu_out[WIDTH-1]),
    .q(st.n)
  );

  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_V])) u_flag_v (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_V]),
    .set(1'b0), .clr(bus.clr_v),
    .alt_en(v_alt_en), .alt_val(v_alt_val),
    .upd_en(v_en), .upd_val(bus.alu_overflow),
    .q(st.v)
  );

  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_D])) u_flag_d (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_D]),
    .set(bus.set_d), .clr(bus.clr_d),
    .alt_en(1'b0), .alt_val(1'b0),
    .upd_en(1'b0), .upd_val(1'b0),
    .q(st.d)
  );

  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_I])) u_flag_i (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_I]),
    .set(bus.set_i | bus.irq_entry), .clr(bus.clr_i),
    .alt_en(1'b0), .alt_val(1'b0),
    .upd_en(1'b0), .upd_val(1'b0),
    .q(st.i)
  );

  // BIT and ALU update both compute Z from the ALU result.
  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_Z])) u_flag_z (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_Z]),
    .set(1'b0), .clr(1'b0),
    .alt_en(bit_en), .alt_val(res_zero),
    .upd_en(nz_en), .upd_val(res_zero),
    .q(st.z)
  );

  flag_bit_cell #(.RST_VAL(RESET_P[FLAG_C])) u_flag_c (
    .clk(clk), .rst(rst),
    .load_en(bus.load_p), .load_val(bus.data_in[FLAG_C]),
    .set(bus.set_c), .clr(bus.clr_c),
    .alt_en(1'b0), .alt_val(1'b0),
    .upd_en(c_en), .upd_val(bus.alu_carry),
    .q(st.c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
    end else if (bus.alu_valid) begin
      result_r <= bus.alu_out;
    end
  end

  assign bus.p_out      = pack_p(st, 1'b0);
  assign bus.push_image = pack_p(st, bus.push_brk);
  assign bus.carry_q    = st.c;
  assign bus.result_q   = result_r;

endmodule
